// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI4 memory arbiter.
// FSM state encodings, grant codes and the round-robin pick.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP
  } wr_state_e;

  localparam logic GNT_S0 = 1'b0;
  localparam logic GNT_S1 = 1'b1;

  // On contention the requester that did not win last time goes first.
  function automatic logic rr_pick(
    input logic [1:0] req,
    input logic       last
  );
    if (&req) return ~last;
    return req[1] ? GNT_S1 : GNT_S0;
  endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin arbiter for one AXI channel group.
// Grant is latched while the channel is idle; last winner updates on done.
module axi_rr_arb2
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       idle,
  input  logic       done,
  output logic       grant,
  output logic       grant_valid
);

  logic last;

  assign grant_valid = idle & (|req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= GNT_S0;
      last  <= 1'b1;
    end else begin
      if (grant_valid) grant <= rr_pick(req, last);
      if (done)        last  <= grant;
    end
  end

endmodule

// File: rtl/axi_mem_arbiter2.sv
// Shares one AXI4 memory port between two masters, one burst per channel.
// Read and write are arbitrated independently; responses follow the grant.
module axi_mem_arbiter2 #(
  parameter int ADDR_W = 36,
  parameter int DATA_W = 64,
  parameter int ID_W   = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  // requester 0
  input  logic [ID_W-1:0]     s0_axi_awid,
  input  logic [ADDR_W-1:0]   s0_axi_awaddr,
  input  logic [7:0]          s0_axi_awlen,
  input  logic [2:0]          s0_axi_awsize, s0_axi_awprot,
  input  logic [1:0]          s0_axi_awburst,
  input  logic                s0_axi_awlock,
  input  logic [3:0]          s0_axi_awcache, s0_axi_awqos,
  input  logic                s0_axi_awvalid,
  output logic                s0_axi_awready,
  input  logic [DATA_W-1:0]   s0_axi_wdata,
  input  logic [DATA_W/8-1:0] s0_axi_wstrb,
  input  logic                s0_axi_wlast, s0_axi_wvalid,
  output logic                s0_axi_wready,
  output logic [ID_W-1:0]     s0_axi_bid,
  output logic [1:0]          s0_axi_bresp,
  output logic                s0_axi_bvalid,
  input  logic                s0_axi_bready,
  input  logic [ID_W-1:0]     s0_axi_arid,
  input  logic [ADDR_W-1:0]   s0_axi_araddr,
  input  logic [7:0]          s0_axi_arlen,
  input  logic [2:0]          s0_axi_arsize, s0_axi_arprot,
  input  logic [1:0]          s0_axi_arburst,
  input  logic                s0_axi_arlock,
  input  logic [3:0]          s0_axi_arcache, s0_axi_arqos,
  input  logic                s0_axi_arvalid,
  output logic                s0_axi_arready,
  output logic [ID_W-1:0]     s0_axi_rid,
  output logic [DATA_W-1:0]   s0_axi_rdata,
  output logic [1:0]          s0_axi_rresp,
  output logic                s0_axi_rlast, s0_axi_rvalid,
  input  logic                s0_axi_rready,
  // requester 1
  input  logic [ID_W-1:0]     s1_axi_awid,
  input  logic [ADDR_W-1:0]   s1_axi_awaddr,
  input  logic [7:0]          s1_axi_awlen,
  input  logic [2:0]          s1_axi_awsize, s1_axi_awprot,
  input  logic [1:0]          s1_axi_awburst,
  input  logic                s1_axi_awlock,
  input  logic [3:0]          s1_axi_awcache, s1_axi_awqos,
  input  logic                s1_axi_awvalid,
  output logic                s1_axi_awready,
  input  logic [DATA_W-1:0]   s1_axi_wdata,
  input  logic [DATA_W/8-1:0] s1_axi_wstrb,
  input  logic                s1_axi_wlast, s1_axi_wvalid,
  output logic                s1_axi_wready,
  output logic [ID_W-1:0]     s1_axi_bid,
  output logic [1:0]          s1_axi_bresp,
  output logic                s1_axi_bvalid,
  input  logic                s1_axi_bready,
  input  logic [ID_W-1:0]     s1_axi_arid,
  input  logic [ADDR_W-1:0]   s1_axi_araddr,
  input  logic [7:0]          s1_axi_arlen,
  input  logic [2:0]          s1_axi_arsize, s1_axi_arprot,
  input  logic [1:0]          s1_axi_arburst,
  input  logic                s1_axi_arlock,
  input  logic [3:0]          s1_axi_arcache, s1_axi_arqos,
  input  logic                s1_axi_arvalid,
  output logic                s1_axi_arready,
  output logic [ID_W-1:0]     s1_axi_rid,
  output logic [DATA_W-1:0]   s1_axi_rdata,
  output logic [1:0]          s1_axi_rresp,
  output logic                s1_axi_rlast, s1_axi_rvalid,
  input  logic                s1_axi_rready,
  // shared memory port
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize, m_axi_awprot,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache, m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast, m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize, m_axi_arprot,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache, m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast, m_axi_rvalid,
  output logic                m_axi_rready,
  output logic                rd_grant,
  output logic                wr_grant
);

  import axi_arb_pkg::*;

  rd_state_e rd_st;
  wr_state_e wr_st;
  logic rd_gnt, rd_gv, rd_done;
  logic wr_gnt, wr_gv, wr_done;
  logic rd_addr, rd_data, wr_xfer, wr_resp;
  logic aw_done, w_done, aw_hs, w_hs;

  assign rd_addr = rd_st == R_ADDR;
  assign rd_data = rd_st == R_DATA;
  assign wr_xfer = wr_st == W_XFER;
  assign wr_resp = wr_st == W_RESP;

  axi_rr_arb2 u_rd_arb (
    .clk        (aclk),
    .rst_n      (aresetn),
    .req        ({s1_axi_arvalid, s0_axi_arvalid}),
    .idle       (rd_st == R_IDLE),
    .done       (rd_done),
    .grant      (rd_gnt),
    .grant_valid(rd_gv)
  );

  axi_rr_arb2 u_wr_arb (
    .clk        (aclk),
    .rst_n      (aresetn),
    .req        ({s1_axi_awvalid, s0_axi_awvalid}),
    .idle       (wr_st == W_IDLE),
    .done       (wr_done),
    .grant      (wr_gnt),
    .grant_valid(wr_gv)
  );

  assign rd_grant = rd_gnt;
  assign wr_grant = wr_gnt;

  // Read FSM
  assign rd_done = rd_data & m_axi_rvalid & m_axi_rready & m_axi_rlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_st <= R_IDLE;
    end else begin
      unique case (rd_st)
        R_IDLE: if (rd_gv) rd_st <= R_ADDR;
        R_ADDR: if (m_axi_arvalid && m_axi_arready) rd_st <= R_DATA;
        R_DATA: if (rd_done) rd_st <= R_IDLE;
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  assign m_axi_arid    = rd_gnt ? s1_axi_arid    : s0_axi_arid;
  assign m_axi_araddr  = rd_gnt ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen   = rd_gnt ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize  = rd_gnt ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst = rd_gnt ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arlock  = rd_gnt ? s1_axi_arlock  : s0_axi_arlock;
  assign m_axi_arcache = rd_gnt ? s1_axi_arcache : s0_axi_arcache;
  assign m_axi_arprot  = rd_gnt ? s1_axi_arprot  : s0_axi_arprot;
  assign m_axi_arqos   = rd_gnt ? s1_axi_arqos   : s0_axi_arqos;
  assign m_axi_arvalid = rd_addr &
    (rd_gnt ? s1_axi_arvalid : s0_axi_arvalid);

  assign s0_axi_arready = rd_addr & ~rd_gnt & m_axi_arready;
  assign s1_axi_arready = rd_addr &  rd_gnt & m_axi_arready;

  assign s0_axi_rid   = m_axi_rid;
  assign s0_axi_rdata = m_axi_rdata;
  assign s0_axi_rresp = m_axi_rresp;
  assign s0_axi_rlast = m_axi_rlast;
  assign s1_axi_rid   = m_axi_rid;
  assign s1_axi_rdata = m_axi_rdata;
  assign s1_axi_rresp = m_axi_rresp;
  assign s1_axi_rlast = m_axi_rlast;

  assign s0_axi_rvalid = rd_data & ~rd_gnt & m_axi_rvalid;
  assign s1_axi_rvalid = rd_data &  rd_gnt & m_axi_rvalid;
  assign m_axi_rready  = rd_data &
    (rd_gnt ? s1_axi_rready : s0_axi_rready);

  // Write FSM: AW and W run concurrently, each gated once it is done
  assign aw_hs   = m_axi_awvalid & m_axi_awready;
  assign w_hs    = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  assign wr_done = wr_resp & m_axi_bvalid & m_axi_bready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_st   <= W_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (wr_st)
        W_IDLE: if (wr_gv) wr_st <= W_XFER;
        W_XFER: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            wr_st   <= W_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        W_RESP: if (wr_done) wr_st <= W_IDLE;
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  assign m_axi_awid    = wr_gnt ? s1_axi_awid    : s0_axi_awid;
  assign m_axi_awaddr  = wr_gnt ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen   = wr_gnt ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize  = wr_gnt ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst = wr_gnt ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awlock  = wr_gnt ? s1_axi_awlock  : s0_axi_awlock;
  assign m_axi_awcache = wr_gnt ? s1_axi_awcache : s0_axi_awcache;
  assign m_axi_awprot  = wr_gnt ? s1_axi_awprot  : s0_axi_awprot;
  assign m_axi_awqos   = wr_gnt ? s1_axi_awqos   : s0_axi_awqos;
  assign m_axi_awvalid = wr_xfer & ~aw_done &
    (wr_gnt ? s1_axi_awvalid : s0_axi_awvalid);

  assign s0_axi_awready = wr_xfer & ~aw_done & ~wr_gnt & m_axi_awready;
  assign s1_axi_awready = wr_xfer & ~aw_done &  wr_gnt & m_axi_awready;

  assign m_axi_wdata  = wr_gnt ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb  = wr_gnt ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast  = wr_gnt ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_wvalid = wr_xfer & ~w_done &
    (wr_gnt ? s1_axi_wvalid : s0_axi_wvalid);

  assign s0_axi_wready = wr_xfer & ~w_done & ~wr_gnt & m_axi_wready;
  assign s1_axi_wready = wr_xfer & ~w_done &  wr_gnt & m_axi_wready;

  assign s0_axi_bid    = m_axi_bid;
  assign s0_axi_bresp  = m_axi_bresp;
  assign s1_axi_bid    = m_axi_bid;
  assign s1_axi_bresp  = m_axi_bresp;
  assign s0_axi_bvalid = wr_resp & ~wr_gnt & m_axi_bvalid;
  assign s1_axi_bvalid = wr_resp &  wr_gnt & m_axi_bvalid;
  assign m_axi_bready  = wr_resp &
    (wr_gnt ? s1_axi_bready : s0_axi_bready);

endmodule
